// File: rtl/cnt_sweep_ctrl_if.sv
// Control/feedback bus between the sweep sequencer and the up/down counter.
// The sequencer (master) drives the counter controls; the counter (slave)
// returns its current value.
interface cnt_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             udbar;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] cnt;

  modport master (output en, output udbar, output ld, output ld_val, input cnt);
  modport slave  (input en, input udbar, input ld, input ld_val, output cnt);
endinterface

// File: rtl/cnt_sweep_ctrl.sv
// Triangle-sweep sequencer for a WIDTH-bit up/down counter.
// Loads lo, counts up to hi, dwells, counts down to lo, dwells, repeats.
// Counter controls are decoded straight from the state register, the fed-back
// count and stop, so the counter reacts in the same cycle the state changes.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting for start; rejects lo >= hi with an err pulse
//   S_LOAD    | one-cycle load of shadow lo into the counter
//   S_UP      | counting up until cnt == hi
//   S_DWELL_HI| holding at hi for dwell cycles
//   S_DOWN    | counting down until cnt == lo; a sweep completes there
//   S_DWELL_LO| holding at lo for dwell cycles before the next sweep
//   S_DONE    | finite run finished; done is registered from this state
module cnt_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         cycles,
  cnt_sweep_ctrl_if.master   ctr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         sweeps
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DWELL_HI,
    S_DOWN,
    S_DWELL_LO,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         cycles_q, cycles_d;
  logic [DWELL_W-1:0] tmr_q, tmr_d;
  logic [7:0]         sweeps_q, sweeps_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               en_c;
  logic               udbar_c;
  logic               ld_c;
  logic [WIDTH-1:0]   ld_val_c;
  logic               busy_c;
  logic               last_sweep;

  // The run ends when the sweep completing now is the programmed count;
  // 9-bit compare so a saturated sweep count cannot alias.
  assign last_sweep = (cycles_q != 8'd0) &&
                      (({1'b0, sweeps_q} + 9'd1) == {1'b0, cycles_q});

  // Next-state, shadow/timer updates and combinational counter controls.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dwell_d  = dwell_q;
    cycles_d = cycles_q;
    tmr_d    = tmr_q;
    sweeps_d = sweeps_q;
    done_d   = (state_q == S_DONE);
    err_d    = 1'b0;
    en_c     = 1'b0;
    udbar_c  = 1'b1;
    ld_c     = 1'b0;
    ld_val_c = '0;
    busy_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (lo >= hi) begin
            err_d = 1'b1;
          end else begin
            lo_d     = lo;
            hi_d     = hi;
            dwell_d  = dwell;
            cycles_d = cycles;
            sweeps_d = 8'd0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        busy_c   = 1'b1;
        ld_c     = 1'b1;
        ld_val_c = lo_q;
        state_d  = S_UP;
      end
      S_UP: begin
        busy_c  = 1'b1;
        udbar_c = 1'b1;
        en_c    = (ctr.cnt != hi_q);
        if (ctr.cnt == hi_q) begin
          if (dwell_q != '0) begin
            tmr_d   = dwell_q - DWELL_W'(1);
            state_d = S_DWELL_HI;
          end else begin
            state_d = S_DOWN;
          end
        end
      end
      S_DWELL_HI: begin
        busy_c  = 1'b1;
        udbar_c = 1'b1;
        if (tmr_q == '0) state_d = S_DOWN;
        else             tmr_d   = tmr_q - DWELL_W'(1);
      end
      S_DOWN: begin
        busy_c  = 1'b1;
        udbar_c = 1'b0;
        en_c    = (ctr.cnt != lo_q);
        if (ctr.cnt == lo_q) begin
          if (sweeps_q != 8'hFF) sweeps_d = sweeps_q + 8'd1;
          if (last_sweep) begin
            state_d = S_DONE;
          end else if (dwell_q != '0) begin
            tmr_d   = dwell_q - DWELL_W'(1);
            state_d = S_DWELL_LO;
          end else begin
            state_d = S_UP;
          end
        end
      end
      S_DWELL_LO: begin
        busy_c  = 1'b1;
        udbar_c = 1'b0;
        if (tmr_q == '0) state_d = S_UP;
        else             tmr_d   = tmr_q - DWELL_W'(1);
      end
      S_DONE: begin
        udbar_c = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort freezes the counter this cycle and discards any sweep credit.
    if (stop && busy_c) begin
      en_c     = 1'b0;
      ld_c     = 1'b0;
      sweeps_d = sweeps_q;
      state_d  = S_IDLE;
    end
  end

  // State, shadow, timer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      dwell_q  <= '0;
      cycles_q <= 8'd0;
      tmr_q    <= '0;
      sweeps_q <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dwell_q  <= dwell_d;
      cycles_q <= cycles_d;
      tmr_q    <= tmr_d;
      sweeps_q <= sweeps_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ctr.en     = en_c;
  assign ctr.udbar  = udbar_c;
  assign ctr.ld     = ld_c;
  assign ctr.ld_val = ld_val_c;
  assign busy       = busy_c;
  assign done       = done_q;
  assign err        = err_q;
  assign sweeps     = sweeps_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Directed bench for cnt_sweep_ctrl driving a behavioural 4-bit up/down
// counter. Expected traces and cycle numbers are hand-computed.
module tb_cnt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] dwell;
  logic [7:0] cycles;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sweeps;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] tr [0:63];
  int         done_cyc;
  int         done_cnt;
  logic       ld_c1;
  logic [3:0] ldv_c1;

  cnt_sweep_ctrl_if #(.WIDTH(4)) bus ();

  cnt_sweep_ctrl #(.WIDTH(4), .DWELL_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .lo     (lo),
    .hi     (hi),
    .dwell  (dwell),
    .cycles (cycles),
    .ctr    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .sweeps (sweeps)
  );

  always #5 clk = ~clk;

  // Counter model: rst, then ld, then en; wraps modulo 16.
  always_ff @(posedge clk) begin
    if (rst)         bus.cnt <= 4'd0;
    else if (bus.ld) bus.cnt <= bus.ld_val;
    else if (bus.en) bus.cnt <= bus.udbar ? bus.cnt + 4'd1 : bus.cnt - 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Start a run in the current cycle (cycle 0) and record ncyc cycles.
  // Inputs are scrambled after the latch; restart_at re-pulses start mid-run.
  task automatic run(input logic [3:0] l, input logic [3:0] h, input logic [3:0] d,
                     input logic [7:0] c, input int ncyc, input int restart_at);
    lo = l; hi = h; dwell = d; cycles = c; start = 1'b1;
    done_cyc = -1; done_cnt = 0;
    tr[0] = bus.cnt;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      start = (k == restart_at);
      if (k == 1) begin
        ld_c1  = bus.ld;
        ldv_c1 = bus.ld_val;
        lo = 4'hF; hi = 4'h0; dwell = 4'hF; cycles = 8'd0;
      end
      tr[k] = bus.cnt;
      if (done) begin
        if (done_cyc < 0) done_cyc = k;
        done_cnt++;
      end
    end
    start = 1'b0;
  endtask

  logic [3:0] exp_single [0:7];
  logic [3:0] exp_dwell  [0:33];
  int         err_cnt;
  int         ld_seen;

  initial begin
    exp_single = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2};
    exp_dwell  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0,
                   4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2,
                   4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3,
                   4'd3, 4'd2, 4'd1, 4'd0};
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    lo = 4'd0; hi = 4'd0; dwell = 4'd0; cycles = 8'd0;

    // Reset defaults
    tick(); tick();
    rst = 1'b0;
    chk("rst_en", bus.en, 0);
    chk("rst_ld", bus.ld, 0);
    chk("rst_udbar", bus.udbar, 1);
    chk("rst_ld_val", bus.ld_val, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sweeps", sweeps, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rst_busy", busy, 0);
      tick();
    end

    // Single sweep lo=2 hi=5 dwell=0 cycles=1
    run(4'd2, 4'd5, 4'd0, 8'd1, 14, -1);
    chk("single_ld", ld_c1, 1);
    chk("single_ld_val", ldv_c1, 2);
    for (int i = 0; i < 8; i++) chk("single_cnt", tr[i+2], exp_single[i]);
    chk("single_done_cyc", done_cyc, 11);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_sweeps", sweeps, 1);
    chk("single_busy_after", busy, 0);

    // Dwell and repeat lo=0 hi=3 dwell=2 cycles=3
    run(4'd0, 4'd3, 4'd2, 8'd3, 42, -1);
    for (int i = 0; i < 34; i++) chk("dwell_cnt", tr[i+2], exp_dwell[i]);
    chk("dwell_done_cyc", done_cyc, 37);
    chk("dwell_done_cnt", done_cnt, 1);
    chk("dwell_sweeps", sweeps, 3);
    chk("dwell_busy_after", busy, 0);

    // Rejected starts: lo == hi, then lo > hi
    for (int r = 0; r < 2; r++) begin
      lo = (r == 0) ? 4'd7 : 4'd9;
      hi = (r == 0) ? 4'd7 : 4'd4;
      start = 1'b1;
      err_cnt = 0; ld_seen = 0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        start = 1'b0;
        if (k == 1) chk("rej_err_c1", err, 1);
        if (err) err_cnt++;
        if (bus.ld) ld_seen++;
        chk("rej_busy", busy, 0);
      end
      chk("rej_err_cnt", err_cnt, 1);
      chk("rej_no_ld", ld_seen, 0);
    end

    // Infinite run with stop: lo=1 hi=15 cycles=0
    lo = 4'd1; hi = 4'd15; dwell = 4'd0; cycles = 8'd0; start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      start = 1'b0;
      if (done) done_cnt++;
      if (k == 15) chk("inf_cnt_c15", bus.cnt, 14);
      if (k == 16) chk("inf_cnt_c16", bus.cnt, 15);
      if (k == 17) chk("inf_cnt_c17", bus.cnt, 15);
    end
    chk("inf_cnt_c24", bus.cnt, 8);
    chk("inf_udbar_c24", bus.udbar, 0);
    chk("inf_en_before_stop", bus.en, 1);
    stop = 1'b1;
    #1;
    chk("stop_en_same_cycle", bus.en, 0);
    chk("stop_ld_same_cycle", bus.ld, 0);
    tick();
    stop = 1'b0;
    if (done) done_cnt++;
    chk("stop_busy_next", busy, 0);
    chk("stop_cnt_frozen", bus.cnt, 8);
    tick();
    if (done) done_cnt++;
    chk("stop_cnt_frozen2", bus.cnt, 8);
    chk("stop_no_done", done_cnt, 0);
    chk("stop_sweeps", sweeps, 0);

    // Reset mid-UP at cnt=4
    lo = 4'd1; hi = 4'd10; dwell = 4'd0; cycles = 8'd0; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
    end
    chk("rst_mid_cnt", bus.cnt, 4);
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_en", bus.en, 0);
    chk("rst_mid_done", done, 0);
    tick();
    chk("rst_mid_idle", busy, 0);

    // Start pulsed during a run is ignored
    run(4'd2, 4'd5, 4'd0, 8'd1, 14, 4);
    for (int i = 0; i < 8; i++) chk("restart_cnt", tr[i+2], exp_single[i]);
    chk("restart_done_cyc", done_cyc, 11);
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
